// File: rtl/uart_time_cmd_rx.sv
// 16x-oversampled UART receiver feeding an ASCII "Chhmm\r" / "Ahhmm\r" / "X\r" command parser.
// Defining UART_PARITY_EN adds an even-parity bit between data bit 7 and the stop bit.
module uart_time_cmd_rx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OVS_DIV  = CLK_FREQ / (BAUD * 16)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    output logic        byte_valid,
    output logic [7:0]  rx_data,
    output logic        set_clock,
    output logic        set_alarm,
    output logic        alarm_off,
    output logic [15:0] time_bcd,
    output logic        cmd_error,
    output logic        rx_busy
);
    localparam int unsigned DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);

    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_X  = 8'h58;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
`ifdef UART_PARITY_EN
        R_PARITY,
`endif
        R_STOP,
        R_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {P_IDLE, P_D0, P_D1, P_D2, P_D3, P_CR, P_X} p_state_t;

    logic             rx_meta, rx_sync;
    logic [1:0]       hi_cnt;
    logic             armed;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    rx_state_t        r_state, r_next;
    logic [3:0]       sc, sc_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shreg, shreg_next;
    logic             load_byte, frm_err, frm_err_q;
`ifdef UART_PARITY_EN
    logic             par_bit, par_next;
`endif

    p_state_t         p_state, p_next;
    logic             mode_alarm, mode_next;
    logic [15:0]      digits, dig_next;
    logic [7:0]       hours;
    logic             range_ok, is_digit;
    logic             clk_d, alm_d, off_d, perr_d, perr_q;

    // Receiver only arms after the synchronized line has really been seen high,
    // so a frame cut by reset is not mistaken for a start bit.
    assign armed    = (hi_cnt == 2'd3);
    assign tick     = (r_state != R_IDLE) && (div_cnt == DIV_LAST);
    assign rx_busy  = (r_state != R_IDLE);
    assign cmd_error = frm_err_q | perr_q;

    always_comb begin
        r_next     = r_state;
        sc_next    = sc;
        bit_next   = bit_idx;
        shreg_next = shreg;
        load_byte  = 1'b0;
        frm_err    = 1'b0;
`ifdef UART_PARITY_EN
        par_next   = par_bit;
`endif
        case (r_state)
            R_IDLE: if (armed && !rx_sync) begin
                r_next  = R_START;
                sc_next = '0;
            end
            R_START: if (tick) begin
                if (sc == 4'd7) begin
                    if (!rx_sync) begin
                        r_next   = R_DATA;
                        sc_next  = '0;
                        bit_next = '0;
                    end else begin
                        r_next = R_IDLE;
                    end
                end else begin
                    sc_next = sc + 4'd1;
                end
            end
            R_DATA: if (tick) begin
                sc_next = sc + 4'd1;
                if (sc == 4'd15) begin
                    shreg_next = {rx_sync, shreg[7:1]};
                    bit_next   = bit_idx + 3'd1;
`ifdef UART_PARITY_EN
                    if (bit_idx == 3'd7) r_next = R_PARITY;
`else
                    if (bit_idx == 3'd7) r_next = R_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            R_PARITY: if (tick) begin
                sc_next = sc + 4'd1;
                if (sc == 4'd15) begin
                    par_next = rx_sync;
                    r_next   = R_STOP;
                end
            end
`endif
            R_STOP: if (tick) begin
                sc_next = sc + 4'd1;
                if (sc == 4'd15) begin
                    if (rx_sync) begin
                        r_next = R_IDLE;
`ifdef UART_PARITY_EN
                        if (par_bit != ^shreg) frm_err = 1'b1;
                        else                   load_byte = 1'b1;
`else
                        load_byte = 1'b1;
`endif
                    end else begin
                        frm_err = 1'b1;
                        r_next  = R_BREAK;
                    end
                end
            end
            R_BREAK: if (rx_sync) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            hi_cnt     <= '0;
            div_cnt    <= '0;
            r_state    <= R_IDLE;
            sc         <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            rx_data    <= '0;
            frm_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            if (!armed) hi_cnt <= rx_sync ? hi_cnt + 2'd1 : 2'd0;
            if (r_state == R_IDLE || div_cnt == DIV_LAST) div_cnt <= '0;
            else                                          div_cnt <= div_cnt + 1'b1;
            r_state    <= r_next;
            sc         <= sc_next;
            bit_idx    <= bit_next;
            shreg      <= shreg_next;
            byte_valid <= load_byte;
            frm_err_q  <= frm_err;
            if (load_byte) rx_data <= shreg;
`ifdef UART_PARITY_EN
            par_bit    <= par_next;
`endif
        end
    end

    always_comb begin
        p_next    = p_state;
        mode_next = mode_alarm;
        dig_next  = digits;
        clk_d     = 1'b0;
        alm_d     = 1'b0;
        off_d     = 1'b0;
        perr_d    = 1'b0;
        is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        hours     = 8'(digits[15:12]) * 8'd10 + 8'(digits[11:8]);
        range_ok  = (digits[15:12] <= 4'd2) && (hours <= 8'd23) && (digits[7:4] <= 4'd5);
        if (frm_err_q) begin
            p_next = P_IDLE;
        end else if (byte_valid) begin
            // 'C'/'A' start a fresh command from any state, including mid-command.
            if (rx_data == CH_C || rx_data == CH_A) begin
                p_next    = P_D0;
                mode_next = (rx_data == CH_A);
            end else begin
                p_next = P_IDLE;
                case (p_state)
                    P_IDLE: begin
                        if (rx_data == CH_X) p_next = P_X;
                        else if (rx_data != CH_CR && rx_data != CH_LF) perr_d = 1'b1;
                    end
                    P_D0: if (is_digit) begin dig_next[15:12] = rx_data[3:0]; p_next = P_D1; end
                          else perr_d = 1'b1;
                    P_D1: if (is_digit) begin dig_next[11:8]  = rx_data[3:0]; p_next = P_D2; end
                          else perr_d = 1'b1;
                    P_D2: if (is_digit) begin dig_next[7:4]   = rx_data[3:0]; p_next = P_D3; end
                          else perr_d = 1'b1;
                    P_D3: if (is_digit) begin dig_next[3:0]   = rx_data[3:0]; p_next = P_CR; end
                          else perr_d = 1'b1;
                    P_CR: begin
                        if (rx_data == CH_CR && range_ok) begin
                            clk_d = !mode_alarm;
                            alm_d = mode_alarm;
                        end else begin
                            perr_d = 1'b1;
                        end
                    end
                    P_X: begin
                        if (rx_data == CH_CR) off_d  = 1'b1;
                        else                  perr_d = 1'b1;
                    end
                    default: p_next = P_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_state    <= P_IDLE;
            mode_alarm <= 1'b0;
            digits     <= '0;
            time_bcd   <= '0;
            set_clock  <= 1'b0;
            set_alarm  <= 1'b0;
            alarm_off  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            p_state    <= p_next;
            mode_alarm <= mode_next;
            digits     <= dig_next;
            set_clock  <= clk_d;
            set_alarm  <= alm_d;
            alarm_off  <= off_d;
            perr_q     <= perr_d;
            if (clk_d || alm_d) time_bcd <= digits;
        end
    end
endmodule

// File: tb/tb_uart_time_cmd_rx.sv
// Bench for uart_time_cmd_rx: serial frames driven on rx, strobes checked against a scoreboard.
// Honours UART_PARITY_EN by inserting the parity bit and running the parity cases.
`timescale 1ns/1ps
module tb_uart_time_cmd_rx;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned OVS      = 2;
    localparam int unsigned CLK_FREQ = BAUD * 16 * OVS;
    localparam int unsigned BIT_CLKS = 16 * OVS;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx      = 1'b1;
    logic        byte_valid;
    logic [7:0]  rx_data;
    logic        set_clock;
    logic        set_alarm;
    logic        alarm_off;
    logic [15:0] time_bcd;
    logic        cmd_error;
    logic        rx_busy;

    uart_time_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx        (rx),
        .byte_valid(byte_valid),
        .rx_data   (rx_data),
        .set_clock (set_clock),
        .set_alarm (set_alarm),
        .alarm_off (alarm_off),
        .time_bcd  (time_bcd),
        .cmd_error (cmd_error),
        .rx_busy   (rx_busy)
    );

    always #5 clock = ~clock;

    typedef enum logic [2:0] {EV_NONE, EV_BYTE, EV_CLK, EV_ALM, EV_OFF, EV_ERR} ev_e;
    typedef struct packed { ev_e kind; logic [15:0] val; } ev_t;
    typedef struct { logic [7:0] b; ev_e ev; logic [15:0] t; } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic observe(input ev_e k, input logic [15:0] v);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event got kind=%0d val=%h required no event", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
                fails++;
                $display("FAIL event got kind=%0d val=%h required kind=%0d val=%h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (set_clock || set_alarm || alarm_off || cmd_error) begin
                tests++;
                if ($countones({set_clock, set_alarm, alarm_off, cmd_error}) > 1) begin
                    fails++;
                    $display("FAIL strobe_exclusive got=%b required one-hot",
                             {set_clock, set_alarm, alarm_off, cmd_error});
                end
            end
            if (byte_valid) observe(EV_BYTE, {8'h00, rx_data});
            if (set_clock)  observe(EV_CLK, time_bcd);
            if (set_alarm)  observe(EV_ALM, time_bcd);
            if (alarm_off)  observe(EV_OFF, time_bcd);
            if (cmd_error)  observe(EV_ERR, time_bcd);
        end
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_ev(input ev_e k, input logic [15:0] v);
        exp_q.push_back('{kind: k, val: v});
    endtask

    // stop_low > 0 holds the stop bit low for that many bit times (break).
    task automatic send_raw(input logic [7:0] b, input int unsigned stop_low);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
`ifdef UART_PARITY_EN
        rx = (^b) ^ par_flip;
        wait_clks(BIT_CLKS);
`endif
        if (stop_low > 0) begin
            rx = 1'b0;
            wait_clks(BIT_CLKS * stop_low);
        end
        rx = 1'b1;
        wait_clks(BIT_CLKS + 8);
    endtask

    task automatic send_byte_exp(input logic [7:0] b, input ev_e ev, input logic [15:0] t);
        push_ev(EV_BYTE, {8'h00, b});
        if (ev != EV_NONE) push_ev(ev, t);
        send_raw(b, 0);
    endtask

    task automatic add_str(input string s, input ev_e last, input logic [15:0] t);
        for (int i = 0; i < s.len(); i++)
            vecs.push_back('{s[i], (i == s.len() - 1) ? last : EV_NONE, t});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_valid"}, 16'(byte_valid), 16'h0);
        check({tag, "_rx_data"},    16'(rx_data),    16'h0);
        check({tag, "_strobes"},    16'({set_clock, set_alarm, alarm_off, cmd_error}), 16'h0);
        check({tag, "_time_bcd"},   time_bcd,        16'h0000);
        check({tag, "_rx_busy"},    16'(rx_busy),    16'h0);
    endtask

    // '2' = 0x32 -> LSB-first bits 0,1,0,0,1,1,0,0: reset lands in high bit 4, releases in low bit 6.
    task automatic reset_mid_frame();
        logic [7:0] pb;
        pb = 8'h32;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            wait_clks(BIT_CLKS);
        end
        rx = pb[4];
        wait_clks(BIT_CLKS / 2);
        reset_n = 1'b0;
        wait_clks(2);
        check_reset_values("midreset");
        wait_clks(BIT_CLKS / 2 - 2);
        rx = pb[5];
        wait_clks(BIT_CLKS);
        rx = pb[6];
        wait_clks(BIT_CLKS / 2);
        reset_n = 1'b1;
        wait_clks(BIT_CLKS / 2);
        rx = pb[7];
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(BIT_CLKS + 8);
        check("after_reset_busy", 16'(rx_busy), 16'h0);
    endtask

    initial begin
        add_str("C1234\r",    EV_CLK,  16'h1234);
        add_str("A0730\r",    EV_ALM,  16'h0730);
        add_str("X\r",        EV_OFF,  16'h0730);
        add_str("C2460\r",    EV_ERR,  16'h0730);
        add_str("C23:",       EV_ERR,  16'h0730);
        add_str("9",          EV_ERR,  16'h0730);
        add_str("\n\r",       EV_NONE, 16'h0730);
        add_str("Z",          EV_ERR,  16'h0730);
        add_str("C12A0815\r", EV_ALM,  16'h0815);
        add_str("C1960\r",    EV_ERR,  16'h0815);
        add_str("C2359\r",    EV_CLK,  16'h2359);
        add_str("XQ",         EV_ERR,  16'h2359);
        add_str("XC0001\r",   EV_CLK,  16'h0001);
        add_str("C12345",     EV_ERR,  16'h0001);

        wait_clks(5);
        check_reset_values("reset");
        reset_n = 1'b1;
        wait_clks(BIT_CLKS);

        for (int i = 0; i < vecs.size(); i++)
            send_byte_exp(vecs[i].b, vecs[i].ev, vecs[i].t);

        // Short low glitch on an idle line must be rejected at the start-bit check.
        rx = 1'b0;
        wait_clks(2 * OVS);
        check("glitch_busy_high", 16'(rx_busy), 16'h1);
        rx = 1'b1;
        for (int i = 0; i < 8 * OVS + 4 && rx_busy; i++) wait_clks(1);
        check("glitch_busy_clear", 16'(rx_busy), 16'h0);
        wait_clks(BIT_CLKS);

        send_byte_exp(8'h43, EV_NONE, 16'h0001);
        send_byte_exp(8'h31, EV_NONE, 16'h0001);
        reset_mid_frame();
        vecs.delete();
        add_str("C1200\r", EV_CLK, 16'h1200);
        for (int i = 0; i < vecs.size(); i++)
            send_byte_exp(vecs[i].b, vecs[i].ev, vecs[i].t);

        send_byte_exp(8'h43, EV_NONE, 16'h1200);
        send_byte_exp(8'h31, EV_NONE, 16'h1200);
        push_ev(EV_ERR, 16'h1200);
        send_raw(8'h55, 2);
        send_byte_exp(8'h32, EV_ERR, 16'h1200);
        vecs.delete();
        add_str("C0000\r", EV_CLK, 16'h0000);
        for (int i = 0; i < vecs.size(); i++)
            send_byte_exp(vecs[i].b, vecs[i].ev, vecs[i].t);

`ifdef UART_PARITY_EN
        par_flip = 1'b1;
        push_ev(EV_ERR, 16'h0000);
        send_raw(8'h43, 0);
        par_flip = 1'b0;
        send_byte_exp(8'h43, EV_NONE, 16'h0000);
`endif

        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) wait_clks(1);
        check("pending_events", 16'(exp_q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_time_cmd_rx.md
Name: uart_time_cmd_rx

Overview:
- Serial-port receive path for the clock/alarm top; it is the input counterpart to the push-button setting path.
- Receives 8N1 UART bytes, oversampled 16x.
- Parses ASCII commands that set clock time, set alarm time, or stop the alarm.
- Emits one-cycle strobes and BCD time for the timekeeping and alarm logic, which also drives the 7-segment display.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVS_DIV, CLK_FREQ/(BAUD*16), clocks per oversample tick; integer truncation; must be >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx  in  1  UART line; idle high; asynchronous to clock.
- byte_valid  out  1  one-cycle pulse when a good byte is received.
- rx_data  out  8  last good byte; held until the next one.
- set_clock  out  1  one-cycle pulse: valid clock-set command accepted.
- set_alarm  out  1  one-cycle pulse: valid alarm-set command accepted.
- alarm_off  out  1  one-cycle pulse: alarm-stop command accepted.
- time_bcd  out  16  {H tens, H units, M tens, M units}, BCD; updated with set_clock/set_alarm only.
- cmd_error  out  1  one-cycle pulse: framing error, bad character or out-of-range time.
- rx_busy  out  1  high from start-bit detect to end of stop bit.

Behaviour:
- Reset values:
  - All pulses 0; rx_data=0x00; time_bcd=0x0000; rx_busy=0.
  - Synchronizer flops = 1; both FSMs in IDLE; counters 0.
- Input: two-flop synchronizer on rx; all logic uses the synchronized value.
- Tick generator: free-running counter 0..OVS_DIV-1 producing a one-cycle tick; forced to 0 when the receiver FSM is in IDLE.
- Receiver FSM (16 ticks per bit, sample count sc 0..15):
  - IDLE: synchronized rx=0 -> START, sc=0, rx_busy=1.
  - START: at sc=7, rx still 0 -> DATA with sc=0 and bit index 0; rx=1 -> IDLE (glitch, no error).
  - DATA: sample at each sc=15 (mid-bit), LSB first; after bit 7 -> STOP.
  - STOP: sample at sc=15.
    - rx=1: rx_data loaded and byte_valid=1 on the same clock, then IDLE.
    - rx=0: cmd_error=1, byte discarded, then wait for rx=1 before IDLE (break handling).
- Parser FSM, advances only on byte_valid:
  - P_IDLE:
    - 0x43 'C' -> P_D0 (mode clock); 0x41 'A' -> P_D0 (mode alarm); 0x58 'X' -> P_X.
    - 0x0D, 0x0A -> ignored.
    - Anything else -> cmd_error, stay.
  - P_D0..P_D3: byte must be 0x30..0x39; store the low nibble and advance. P_D3 -> P_CR.
  - P_CR: byte 0x0D -> range check: H = D0*10+D1 <= 23, D0 <= 2, D2 <= 5.
    - Pass: time_bcd loaded and set_clock or set_alarm pulsed on the cycle after byte_valid.
    - Fail: cmd_error. Either way -> P_IDLE.
  - P_X: 0x0D -> alarm_off pulse the cycle after byte_valid; otherwise cmd_error. Then P_IDLE.
  - In any non-idle state, 'C' or 'A' restarts the command (no error); any other unexpected byte -> cmd_error and P_IDLE.
  - A framing error in any parser state -> parser returns to P_IDLE.
- Strobe exclusivity: set_clock, set_alarm, alarm_off and cmd_error are mutually exclusive in any cycle.
- Latency: stop-bit mid-sample -> byte_valid same cycle; command strobes 1 cycle later.
- Reset mid-frame or mid-command: everything returns to reset values immediately; a partial command is lost. A frame in progress on release is ignored until the line has been high and a new falling edge is seen.

Optional Feature:
- Macro UART_PARITY_EN.
  - Defined: the frame has an even-parity bit between bit 7 and stop, sampled at sc=15. A mismatch gives cmd_error at stop-bit sampling, the byte is discarded, and the parser resets.
  - Undefined: 8N1 with no parity state; ports unchanged.

Test Plan:
- "C1234\r" at 9600 baud, 50 MHz -> one set_clock pulse, time_bcd=0x1234, no cmd_error; byte_valid pulses 6 times with rx_data ending 0x0D.
- "A0730\r" -> set_alarm pulse, time_bcd=0x0730. Then "X\r" -> alarm_off pulse, time_bcd still 0x0730.
- "C2460\r" -> cmd_error on the CR cycle, no set_clock, time_bcd unchanged. "C23:9" -> cmd_error at ':', parser idle.
- Frame with stop bit held 0 for 2 bit times -> cmd_error once, no byte_valid; the following "C0000\r" is accepted normally.
- 2-tick low glitch on idle rx -> no byte_valid, rx_busy returns to 0 within 8 ticks. reset_n low during the 3rd byte of "C1200\r", then resend -> only one set_clock, after the resend.
- With UART_PARITY_EN: 'C' (0x43) sent with parity bit 0 -> cmd_error, no byte_valid; with parity bit 1 -> byte_valid with rx_data=0x43.
